fetch_stage: RTL and testbench

Instruction fetch stage that sits directly upstream of the decode/control unit in the single-cycle CPU datapath. It owns the program counter, drives the combinational instruction memory address, and buffers fetched instructions with their PCs in a 2-entry FIFO. It presents them to decode through a valid/ready handshake, supports redirects (jump/branch) that flush the buffer, and stops on a halt opcode.

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the program counter, drives the instruction memory
// address, buffers fetched {pc, instruction} pairs in a 2-entry FIFO and
// hands them to decode over a valid/ready handshake. Redirects flush the
// buffer; fetching stops after a halt opcode is pushed.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INS_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INS_W-1:0]  ins_out,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              halted
);

  // Architectural state
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        count_q, count_d;
  logic              head_q, head_d;
  logic              halted_q, halted_d;
  logic [ADDR_W-1:0] fpc_q [2];
  logic [ADDR_W-1:0] fpc_d [2];
  logic [INS_W-1:0]  fins_q [2];
  logic [INS_W-1:0]  fins_d [2];

  // Handshake / control strobes
  logic       pop_s;
  logic       fetch_s;
  logic       wr_idx_s;
  logic [3:0] opcode_s;

  // Outputs are direct views of registered state
  assign imem_addr = pc_q;
  assign ins_valid = (count_q != 2'd0);
  assign ins_out   = fins_q[head_q];
  assign ins_pc    = fpc_q[head_q];
  assign halted    = halted_q;

  // Strobe decode: a full FIFO can still accept a push when the head leaves
  always_comb begin
    opcode_s = imem_data[INS_W-1 -: 4];
    pop_s    = ins_valid & ins_ready;
    fetch_s  = !halted_q && !redirect_valid && ((count_q < 2'd2) || pop_s);
    // With two entries the tail slot coincides with the head slot that is
    // being vacated, so head + count[0] is the write index in all cases.
    wr_idx_s = head_q ^ count_q[0];
  end

  // Next-state computation for PC, FIFO pointers, storage and halt flag
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    head_d   = head_q;
    halted_d = halted_q;
    fpc_d    = fpc_q;
    fins_d   = fins_q;

    if (redirect_valid) begin
      // Redirect wins over fetch/halt; any same-cycle pop is absorbed by the flush
      pc_d     = redirect_pc;
      count_d  = 2'd0;
      head_d   = 1'b0;
      halted_d = 1'b0;
    end else begin
      if (fetch_s) begin
        fpc_d[wr_idx_s]  = pc_q;
        fins_d[wr_idx_s] = imem_data;
        pc_d             = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (opcode_s == HALT_OP) begin
          halted_d = 1'b1;
        end else begin
          halted_d = halted_q;
        end
      end else begin
        pc_d = pc_q;
      end

      if (pop_s) begin
        head_d = ~head_q;
      end else begin
        head_d = head_q;
      end

      case ({fetch_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with asynchronous active-low reset clearing all storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      halted_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fpc_q[i]  <= '0;
        fins_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      head_q   <= head_d;
      halted_q <= halted_d;
      for (int i = 0; i < 2; i++) begin
        fpc_q[i]  <= fpc_d[i];
        fins_q[i] <= fins_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues the {pc, instruction}
// pairs decode must receive; a negedge monitor pops and compares on every
// accepted handshake. Direct checks cover reset, backpressure and bubbles.
module tb_fetch_stage;

  logic       clk;
  logic       reset;
  logic [7:0] imem_addr;
  logic [15:0] imem_data;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       ins_valid;
  logic       ins_ready;
  logic [15:0] ins_out;
  logic [7:0] ins_pc;
  logic       halted;

  int vectors;
  int miscompares;
  logic [23:0] exp_q[$];

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_out        (ins_out),
    .ins_pc         (ins_pc),
    .halted         (halted)
  );

  // Clock: period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: mem[a] = 16'h1000 | a, mem[5] = 16'hF000
  assign imem_data = (imem_addr == 8'd5) ? 16'hF000 : (16'h1000 | {8'h00, imem_addr});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [7:0] pc, input logic [15:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  task automatic expect_run(input logic [7:0] first, input int n);
    logic [7:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      expect_pc(a, (a == 8'd5) ? 16'hF000 : (16'h1000 | {8'h00, a}));
      a = a + 8'd1;
    end
  endtask

  // Monitor: every accepted head must match the next scoreboard entry
  always @(negedge clk) begin
    logic [23:0] e;
    if (reset && ins_valid && ins_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_delivery: got pc=%h ins=%h expected nothing", ins_pc, ins_out);
      end else begin
        e = exp_q.pop_front();
        if ({ins_pc, ins_out} !== e) begin
          miscompares++;
          $display("FAIL delivery: got pc=%h ins=%h expected pc=%h ins=%h",
                   ins_pc, ins_out, e[23:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    ins_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    repeat (2) cyc();

    // Reset state
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h00);
    chk("rst_ins_out", 32'(ins_out), 32'h0000);
    chk("rst_ins_pc", 32'(ins_pc), 32'h00);

    // Stream from reset into the halt at pc 5
    expect_run(8'h00, 6);
    ins_ready = 1'b1;
    reset     = 1'b1;
    chk("pre_edge_valid", 32'(ins_valid), 32'd0);
    cyc();
    chk("c0_valid", 32'(ins_valid), 32'd1);
    chk("c0_head_pc", 32'(ins_pc), 32'h00);
    chk("c0_head_ins", 32'(ins_out), 32'h1000);
    chk("c0_addr", 32'(imem_addr), 32'h01);
    repeat (8) cyc();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_drained", 32'(ins_valid), 32'd0);
    chk("halt_addr", 32'(imem_addr), 32'h06);

    // Redirect out of halted state with backpressure
    ins_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_unhalt", 32'(halted), 32'd0);
    chk("redir_bubble", 32'(ins_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    cyc();
    chk("redir_valid", 32'(ins_valid), 32'd1);
    chk("redir_head_pc", 32'(ins_pc), 32'h40);
    chk("redir_head_ins", 32'(ins_out), 32'h1040);
    repeat (2) cyc();
    chk("redir_full_addr", 32'(imem_addr), 32'h42);
    chk("redir_full_head", 32'(ins_pc), 32'h40);

    // Redirect to FE with a full FIFO and a same-cycle pop of 40
    expect_pc(8'h40, 16'h1040);
    ins_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    cyc();
    redirect_valid = 1'b0;
    chk("flush_bubble", 32'(ins_valid), 32'd0);
    chk("flush_addr", 32'(imem_addr), 32'hFE);
    expect_run(8'hFE, 8);
    repeat (12) cyc();
    chk("wrap_halt", 32'(halted), 32'd1);
    chk("wrap_drained", 32'(ins_valid), 32'd0);
    chk("wrap_addr", 32'(imem_addr), 32'h06);

    // Asynchronous reset from halted state, then backpressure
    ins_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_addr", 32'(imem_addr), 32'h00);
    chk("async_valid", 32'(ins_valid), 32'd0);
    repeat (2) cyc();
    reset = 1'b1;
    repeat (2) cyc();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_addr", 32'(imem_addr), 32'h02);
      chk("bp_head_pc", 32'(ins_pc), 32'h00);
      chk("bp_head_ins", 32'(ins_out), 32'h1000);
    end

    // Reset mid-operation while count == 2
    #2;
    reset = 1'b0;
    #1;
    chk("mid_valid", 32'(ins_valid), 32'd0);
    chk("mid_halted", 32'(halted), 32'd0);
    chk("mid_addr", 32'(imem_addr), 32'h00);
    cyc();
    reset = 1'b1;
    repeat (3) cyc();
    chk("restart_addr", 32'(imem_addr), 32'h02);
    chk("restart_head", 32'(ins_pc), 32'h00);

    // Ready returns: no gaps or duplicates through to halt
    expect_run(8'h00, 6);
    ins_ready = 1'b1;
    repeat (10) cyc();
    chk("final_halt", 32'(halted), 32'd1);
    chk("final_drained", 32'(ins_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
